usart_rx_deframer: RTL

//  - Serial receiver paired with the USART transmitter: consumes the tx line and recovers bytes.
//  - Frame format: idle-high, 1 start (0), DATA_BIT data bits LSB first, 1 stop (1).
//  - Delivers each byte on a valid/ready output register. Flags framing and overrun errors.

---
 rtl/usart_rx_deframer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/usart_rx_deframer.sv
// usart_rx_deframer
//   Serial receiver for an idle-high line: 1 start bit (0), DATA_BIT data
//   bits LSB first, optional even parity bit, 1 stop bit (1). Each good byte
//   is presented on a valid/ready output register; framing, parity and
//   overrun conditions are reported as one-cycle pulses.
//
// Optional feature macro: USART_RX_PARITY_EN
//   defined   : even-parity bit follows the data bits, checked before stop.
//   undefined : no parity bit, parity_err tied 0.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   asynchronous active-low reset
//   rx         in   serial line, asynchronous to clk
//   data       out  received byte, bits [7:DATA_BIT] always 0
//   valid      out  data holds an unread byte
//   ready      in   consumer accepts data when valid && ready
//   frame_err  out  pulse: stop bit sampled 0
//   overrun    out  pulse: byte completed while valid && !ready (byte dropped)
//   parity_err out  pulse: parity mismatch (byte dropped)
module usart_rx_deframer #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BIT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);
  localparam logic [3:0]  IDX_LAST     = 4'(DATA_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef USART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  // Synchronizer (rx_s2_q is the synchronized line) plus one history flop
  // used for falling-edge detection in IDLE.
  logic rx_s1_q;
  logic rx_s2_q;
  logic rx_prev_q;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  idx_q;
  logic [7:0]  shift_q;
  logic        done_q;     // good stop sampled, deliver on the next edge

  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        ovr_q;

`ifdef USART_RX_PARITY_EN
  logic        par_bad_q;
  logic        perr_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef USART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef USART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif

      // Output register. A completing byte wins over a plain handshake:
      // if the old byte is being taken this cycle the new one replaces it
      // and valid stays high; if it is not being taken the new byte drops.
      if (done_q) begin
        if (valid_q && !ready) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s2_q) begin
              state_q <= IDLE;           // false start
            end else begin
              state_q <= DATA;
              idx_q   <= '0;
              shift_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q                 <= '0;
            shift_q[idx_q[2:0]]   <= rx_s2_q;
            if (idx_q == IDX_LAST) begin
              idx_q <= '0;
`ifdef USART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

`ifdef USART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            // Even parity: line bit must equal XOR of the data bits.
            par_bad_q <= rx_s2_q ^ (^shift_q);
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif

        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s2_q) begin
              state_q <= IDLE;
`ifdef USART_RX_PARITY_EN
              if (par_bad_q) perr_q <= 1'b1;
              else           done_q <= 1'b1;
`else
              done_q <= 1'b1;
`endif
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        BREAK: begin
          if (rx_s2_q) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef USART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
